// File: rtl/flag_sync_pkg.sv
// Shared constants and helpers for the multi-channel receive-side flag synchronizer.
// Holds the width derivations and the parameter legality rule used by the top level.
package flag_sync_pkg;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_CNT_W       = 8;
  localparam int MAX_N_CH        = 32;
  localparam int MIN_SYNC_STAGES = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'd1 << i) < v) ? i + 1 : r;
    end
    return r;
  endfunction

  // Channel index width never collapses to zero, even for a single channel
  function automatic int chWidth(input int nCh);
    return (clog2(nCh) < 1) ? 1 : clog2(nCh);
  endfunction

  function automatic bit paramsLegal(input int nCh, input int syncStages, input int cntW);
    return (nCh >= 1) && (nCh <= MAX_N_CH) && (syncStages >= MIN_SYNC_STAGES) && (cntW >= 1);
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/flag_sync_rx_array_chan.sv
// One receive channel: toggle synchronizer, edge detect, sticky pending and overflow flags.
// A detect coinciding with this channel's own consume re-arms pend instead of dropping.
module flag_sync_chan
  import flag_sync_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flagTgl,
  input  logic armed,
  input  logic consume,
  input  logic ovfClr,
  output logic drop,
  output logic flagPulse,
  output logic pend,
  output logic ovf
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_r;
  logic hist_r;
  logic flagPulse_r;
  logic pend_r;
  logic ovf_r;
  logic det_s;
  logic drop_s;
  logic pendNext_s;
  logic ovfNext_s;

  // Edge detect plus next-state of the sticky pending and overflow flags
  always_comb begin
    det_s  = armed & (sync_r[SYNC_STAGES-1] ^ hist_r);
    drop_s = det_s & pend_r & ~consume;
    if (det_s) begin
      pendNext_s = 1'b1;
    end else if (consume) begin
      pendNext_s = 1'b0;
    end else begin
      pendNext_s = pend_r;
    end
    if (drop_s) begin
      ovfNext_s = 1'b1;
    end else if (ovfClr) begin
      ovfNext_s = 1'b0;
    end else begin
      ovfNext_s = ovf_r;
    end
  end

  // Synchronizer chain, history flop and registered channel state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r      <= '0;
      hist_r      <= 1'b0;
      flagPulse_r <= 1'b0;
      pend_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], flagTgl};
      hist_r      <= sync_r[SYNC_STAGES-1];
      flagPulse_r <= det_s;
      pend_r      <= pendNext_s;
      ovf_r       <= ovfNext_s;
    end
  end

  assign drop      = drop_s;
  assign flagPulse = flagPulse_r;
  assign pend      = pend_r;
  assign ovf       = ovf_r;

endmodule

// File: rtl/flag_sync_rx_array.sv
// Multi-channel toggle-flag receiver: per-channel synchronizers, warm-up gating,
// round-robin event offer with ack toggles, and a saturating drop counter.
module flag_sync_rx_array
  import flag_sync_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  localparam int CH_W       = chWidth(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  flag_tgl_in,
  output logic [N_CH-1:0]  flag_pulse,
  output logic [N_CH-1:0]  pend,
  output logic             evt_valid,
  output logic [CH_W-1:0]  evt_ch,
  input  logic             evt_ready,
  output logic [N_CH-1:0]  ack_tgl_out,
  output logic [N_CH-1:0]  ovf,
  input  logic [N_CH-1:0]  ovf_clr,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             cnt_clr
);

  localparam int WARM_W                   = clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);
  localparam logic [CH_W:0] N_CH_EXT      = (CH_W + 1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH     = CH_W'(N_CH - 1);
  localparam int SUM_W                    = CNT_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  if (!paramsLegal(N_CH, SYNC_STAGES, CNT_W)) begin : gBadParams
    $error("flag_sync_rx_array: illegal N_CH / SYNC_STAGES / CNT_W");
  end

  logic [WARM_W-1:0] warmCnt_r;
  logic [CH_W-1:0]   rrPtr_r;
  logic [N_CH-1:0]   ackTgl_r;
  logic [CNT_W-1:0]  dropCnt_r;

  logic                armed_s;
  logic [N_CH-1:0]     drop_s;
  logic [2*N_CH-1:0]   rot_s;
  logic                found_s;
  logic [CH_W:0]       pick_s;
  logic [CH_W-1:0]     evtCh_s;
  logic                hs_s;
  logic [N_CH-1:0]     consume_s;
  logic [CH_W-1:0]     nextPtr_s;
  logic [5:0]          dropCount_s;
  logic [CNT_W-1:0]    cntBase_s;
  logic [SUM_W-1:0]    cntSum_s;
  logic [CNT_W-1:0]    dropCntNext_s;

  assign armed_s = (warmCnt_r == WARM_DONE);

  for (genvar i = 0; i < N_CH; i++) begin : gChan
    flag_sync_chan #(
      .SYNC_STAGES(SYNC_STAGES)
    ) uChan (
      .clk       (clk),
      .rst_n     (rst_n),
      .flagTgl   (flag_tgl_in[i]),
      .armed     (armed_s),
      .consume   (consume_s[i]),
      .ovfClr    (ovf_clr[i]),
      .drop      (drop_s[i]),
      .flagPulse (flag_pulse[i]),
      .pend      (pend[i]),
      .ovf       (ovf[i])
    );
  end

  // Round-robin pick: rotate pend down by rrPtr, take the lowest set bit, map back
  always_comb begin
    rot_s   = {pend, pend} >> rrPtr_r;
    found_s = 1'b0;
    pick_s  = {1'b0, rrPtr_r};
    for (int k = 0; k < N_CH; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        pick_s  = {1'b0, rrPtr_r} + (CH_W + 1)'(k);
      end else begin
        found_s = found_s;
      end
    end
    if (!found_s) begin
      evtCh_s = '0;
    end else if (pick_s >= N_CH_EXT) begin
      evtCh_s = CH_W'(pick_s - N_CH_EXT);
    end else begin
      evtCh_s = pick_s[CH_W-1:0];
    end
    hs_s = found_s & evt_ready;
    if (hs_s) begin
      consume_s = N_CH'(1'b1) << evtCh_s;
    end else begin
      consume_s = '0;
    end
    if (evtCh_s == LAST_CH) begin
      nextPtr_s = '0;
    end else begin
      nextPtr_s = evtCh_s + CH_W'(1'b1);
    end
  end

  // Saturating drop accumulation; a clear only discards the previous total
  always_comb begin
    dropCount_s = popcount32(32'(drop_s));
    if (cnt_clr) begin
      cntBase_s = '0;
    end else begin
      cntBase_s = dropCnt_r;
    end
    cntSum_s = SUM_W'(cntBase_s) + SUM_W'(dropCount_s);
    if (cntSum_s > SUM_W'(CNT_MAX)) begin
      dropCntNext_s = CNT_MAX;
    end else begin
      dropCntNext_s = cntSum_s[CNT_W-1:0];
    end
  end

  // Warm-up counter, arbiter pointer, ack toggles and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warmCnt_r <= '0;
      rrPtr_r   <= '0;
      ackTgl_r  <= '0;
      dropCnt_r <= '0;
    end else begin
      if (!armed_s) begin
        warmCnt_r <= warmCnt_r + WARM_W'(1'b1);
      end else begin
        warmCnt_r <= warmCnt_r;
      end
      if (hs_s) begin
        rrPtr_r <= nextPtr_s;
      end else begin
        rrPtr_r <= rrPtr_r;
      end
      ackTgl_r  <= ackTgl_r ^ consume_s;
      dropCnt_r <= dropCntNext_s;
    end
  end

  assign evt_valid   = found_s;
  assign evt_ch      = evtCh_s;
  assign ack_tgl_out = ackTgl_r;
  assign drop_cnt    = dropCnt_r;

endmodule

// File: tb/tb_flag_sync_rx_array.sv
// Directed bench for flag_sync_rx_array (N_CH=4, SYNC_STAGES=3, CNT_W=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_flag_sync_rx_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] flag_tgl_in;
  logic [3:0] flag_pulse;
  logic [3:0] pend;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_ready;
  logic [3:0] ack_tgl_out;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;
  logic [1:0] drop_cnt;
  logic       cnt_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_sync_rx_array #(.N_CH(4), .SYNC_STAGES(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flag_tgl_in(flag_tgl_in), .flag_pulse(flag_pulse),
    .pend(pend), .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_ready(evt_ready),
    .ack_tgl_out(ack_tgl_out), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt),
    .cnt_clr(cnt_clr)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input logic [3:0] lvl);
    rst_n = 1'b0; flag_tgl_in = lvl; evt_ready = 1'b0; ovf_clr = 4'b0; cnt_clr = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
  endtask

  task automatic test_reset;
    logic [3:0] seen;
    rst_n = 1'b0; flag_tgl_in = 4'b1010; evt_ready = 1'b0; ovf_clr = 4'b0; cnt_clr = 1'b0;
    step(2);
    checks++;
    if ({flag_pulse, pend, ack_tgl_out, ovf} !== 16'h0000) begin
      errors++; $display("FAIL reset_vec: got %h expected 0000", {flag_pulse, pend, ack_tgl_out, ovf});
    end
    checks++;
    if ({evt_valid, evt_ch, drop_cnt} !== 5'b0) begin
      errors++; $display("FAIL reset_arb: got %b expected 00000", {evt_valid, evt_ch, drop_cnt});
    end
    rst_n = 1'b1;
    seen = 4'b0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      seen = seen | flag_pulse | pend;
    end
    checks++;
    if (seen !== 4'b0000) begin
      errors++; $display("FAIL warmup_no_event: got %b expected 0000", seen);
    end
  endtask

  task automatic test_single_latency;
    logic [3:0] seen;
    flag_tgl_in[2] = ~flag_tgl_in[2];
    seen = 4'b0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      seen = seen | flag_pulse | pend;
    end
    checks++;
    if (seen !== 4'b0000) begin
      errors++; $display("FAIL early_detect: got %b expected 0000", seen);
    end
    step(1);
    checks++;
    if (flag_pulse !== 4'b0100) begin
      errors++; $display("FAIL latency_pulse: got %b expected 0100", flag_pulse);
    end
    checks++;
    if ({pend, evt_valid, evt_ch} !== 7'b0100_1_10) begin
      errors++; $display("FAIL latency_offer: got %b expected 0100110", {pend, evt_valid, evt_ch});
    end
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    checks++;
    if ({flag_pulse, pend, ack_tgl_out, evt_valid} !== 13'b0000_0000_0100_0) begin
      errors++; $display("FAIL consume: got %b expected 0000000001000", {flag_pulse, pend, ack_tgl_out, evt_valid});
    end
  endtask

  task automatic runRR(input logic [3:0] mask, output logic [5:0] seq, output int n);
    flag_tgl_in = flag_tgl_in ^ mask;
    seq = 6'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (evt_valid && n < 3) begin
        seq = {evt_ch, seq[5:2]};
        n++;
      end
    end
  endtask

  task automatic test_round_robin;
    logic [5:0] seq;
    int n;
    doReset(4'b0000);
    evt_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      runRR(4'b1011, seq, n);
      checks++;
      if (n !== 3 || seq !== 6'b11_01_00) begin
        errors++; $display("FAIL rr_from0 round %0d: got n=%0d seq=%b expected n=3 seq=110100", r, n, seq);
      end
    end
    runRR(4'b0010, seq, n);
    checks++;
    if (n !== 1 || seq[5:4] !== 2'd1) begin
      errors++; $display("FAIL rr_single: got n=%0d ch=%0d expected n=1 ch=1", n, seq[5:4]);
    end
    runRR(4'b1011, seq, n);
    checks++;
    if (n !== 3 || seq !== 6'b01_00_11) begin
      errors++; $display("FAIL rr_from2: got n=%0d seq=%b expected n=3 seq=010011", n, seq);
    end
    checks++;
    if ({ack_tgl_out, pend} !== 8'b1001_0000) begin
      errors++; $display("FAIL rr_ack: got %b expected 10010000", {ack_tgl_out, pend});
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_drop;
    doReset(4'b0000);
    flag_tgl_in[1] = ~flag_tgl_in[1];
    step(6);
    flag_tgl_in[1] = ~flag_tgl_in[1];
    step(4);
    checks++;
    if ({ovf, drop_cnt, pend} !== 10'b0010_01_0010) begin
      errors++; $display("FAIL drop_single: got %b expected 0010010010", {ovf, drop_cnt, pend});
    end
    flag_tgl_in = flag_tgl_in ^ 4'b1001;
    step(5);
    checks++;
    if ({pend, drop_cnt} !== 6'b1011_01) begin
      errors++; $display("FAIL drop_prefill: got %b expected 101101", {pend, drop_cnt});
    end
    flag_tgl_in = flag_tgl_in ^ 4'b1001;
    step(4);
    checks++;
    if ({ovf, drop_cnt} !== 6'b1011_11) begin
      errors++; $display("FAIL drop_double: got %b expected 101111", {ovf, drop_cnt});
    end
    flag_tgl_in[1] = ~flag_tgl_in[1];
    step(3);
    ovf_clr = 4'b0010;
    step(1);
    ovf_clr = 4'b0000;
    checks++;
    if ({ovf, drop_cnt} !== 6'b1011_11) begin
      errors++; $display("FAIL ovf_set_wins: got %b expected 101111", {ovf, drop_cnt});
    end
    ovf_clr = 4'b1000;
    step(1);
    ovf_clr = 4'b0000;
    checks++;
    if (ovf !== 4'b0011) begin
      errors++; $display("FAIL ovf_clear: got %b expected 0011", ovf);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] expCnt;
    doReset(4'b0000);
    flag_tgl_in = flag_tgl_in ^ 4'b1111;
    step(5);
    checks++;
    if ({pend, drop_cnt} !== 6'b1111_00) begin
      errors++; $display("FAIL sat_prefill: got %b expected 111100", {pend, drop_cnt});
    end
    for (int k = 0; k < 5; k++) begin
      flag_tgl_in = flag_tgl_in ^ (4'b0001 << (k % 4));
      step(4);
      expCnt = (k >= 2) ? 2'd3 : 2'(k + 1);
      checks++;
      if (drop_cnt !== expCnt) begin
        errors++; $display("FAIL sat_drop %0d: got %0d expected %0d", k, drop_cnt, expCnt);
      end
    end
    flag_tgl_in[2] = ~flag_tgl_in[2];
    step(3);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    checks++;
    if (drop_cnt !== 2'd1) begin
      errors++; $display("FAIL clr_with_drop: got %0d expected 1", drop_cnt);
    end
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    checks++;
    if (drop_cnt !== 2'd0) begin
      errors++; $display("FAIL clr_only: got %0d expected 0", drop_cnt);
    end
  endtask

  task automatic test_race;
    doReset(4'b0000);
    flag_tgl_in[2] = ~flag_tgl_in[2];
    step(5);
    checks++;
    if (pend !== 4'b0100) begin
      errors++; $display("FAIL race_prefill: got %b expected 0100", pend);
    end
    flag_tgl_in[2] = ~flag_tgl_in[2];
    step(3);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    checks++;
    if ({pend, ack_tgl_out, flag_pulse} !== 12'b0100_0100_0100) begin
      errors++; $display("FAIL race_state: got %b expected 010001000100", {pend, ack_tgl_out, flag_pulse});
    end
    checks++;
    if ({ovf, drop_cnt} !== 6'b0) begin
      errors++; $display("FAIL race_no_drop: got %b expected 000000", {ovf, drop_cnt});
    end
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    checks++;
    if ({pend, ack_tgl_out} !== 8'b0000_0000) begin
      errors++; $display("FAIL race_second_consume: got %b expected 00000000", {pend, ack_tgl_out});
    end
  endtask

  task automatic test_async_reset;
    flag_tgl_in[1] = ~flag_tgl_in[1];
    step(5);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    flag_tgl_in[3] = ~flag_tgl_in[3];
    step(5);
    checks++;
    if ({pend, ack_tgl_out} !== 8'b1000_0010) begin
      errors++; $display("FAIL pre_async: got %b expected 10000010", {pend, ack_tgl_out});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pend, ack_tgl_out, evt_valid} !== 9'b0) begin
      errors++; $display("FAIL async_reset: got %b expected 000000000", {pend, ack_tgl_out, evt_valid});
    end
    flag_tgl_in = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_latency();
    test_round_robin();
    test_drop();
    test_saturation();
    test_race();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
